// File: rtl/dac_audio_sched.sv
// Two-channel sample scheduler for the shared 4-bit PWM audio DAC.
// Per-channel FIFOs are popped once per frame; the DAC code is mixed or selected and held for the frame.
module dac_audio_sched #(
    parameter int FRAME_LEN  = 512,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [3:0] ch0_data,
    input  logic       ch0_valid,
    output logic       ch0_ready,
    input  logic [3:0] ch1_data,
    input  logic       ch1_valid,
    output logic       ch1_ready,
    input  logic [1:0] mode,
    input  logic       clr_underrun,
    output logic [3:0] dac_data,
    output logic       frame_tick,
    output logic [1:0] underrun
);

    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [15:0] CNT_RELOAD = 16'(FRAME_LEN - 1);

    logic [15:0] frame_cnt;
    logic [3:0]  mem0 [FIFO_DEPTH];
    logic [3:0]  mem1 [FIFO_DEPTH];
    logic [AW:0] wr_ptr0, rd_ptr0, wr_ptr1, rd_ptr1;
    logic        empty0, full0, empty1, full1;
    logic        push0, push1, sel0, sel1, pop0, pop1;
    logic        rr;
    logic [3:0]  last0, last1, nxt_last0, nxt_last1, dac_nxt_p0;
    logic [1:0]  urun_set;

    function automatic logic [3:0] round_avg(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] sum;
        sum = {1'b0, a} + {1'b0, b} + 5'd1;
        return sum[4:1];
    endfunction

    // Full when the pointers differ only in the extra wrap bit.
    assign empty0    = (wr_ptr0 == rd_ptr0);
    assign full0     = (wr_ptr0 == {~rd_ptr0[AW], rd_ptr0[AW-1:0]});
    assign empty1    = (wr_ptr1 == rd_ptr1);
    assign full1     = (wr_ptr1 == {~rd_ptr1[AW], rd_ptr1[AW-1:0]});
    assign ch0_ready = ~full0;
    assign ch1_ready = ~full1;
    assign push0     = ch0_valid & ~full0;
    assign push1     = ch1_valid & ~full1;

    always_comb begin
        sel0 = 1'b0;
        sel1 = 1'b0;
        case (mode)
            2'b00:   begin sel0 = 1'b1; sel1 = 1'b1; end
            2'b01:   sel0 = 1'b1;
            2'b10:   sel1 = 1'b1;
            default: begin sel0 = ~rr; sel1 = rr; end
        endcase
    end

    assign pop0      = frame_tick & sel0 & ~empty0;
    assign pop1      = frame_tick & sel1 & ~empty1;
    assign urun_set  = {frame_tick & sel1 & empty1, frame_tick & sel0 & empty0};
    assign nxt_last0 = pop0 ? mem0[rd_ptr0[AW-1:0]] : last0;
    assign nxt_last1 = pop1 ? mem1[rd_ptr1[AW-1:0]] : last1;

    always_comb begin
        dac_nxt_p0 = nxt_last0;
        case (mode)
            2'b00:   dac_nxt_p0 = round_avg(nxt_last0, nxt_last1);
            2'b01:   dac_nxt_p0 = nxt_last0;
            2'b10:   dac_nxt_p0 = nxt_last1;
            default: dac_nxt_p0 = rr ? nxt_last1 : nxt_last0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (push0) mem0[wr_ptr0[AW-1:0]] <= ch0_data;
        if (push1) mem1[wr_ptr1[AW-1:0]] <= ch1_data;
    end

    // Stage p0 -> p1: frame_tick cycle selects/pops, DAC code registered one clock later.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_cnt  <= CNT_RELOAD;
            frame_tick <= 1'b0;
            wr_ptr0    <= '0;
            rd_ptr0    <= '0;
            wr_ptr1    <= '0;
            rd_ptr1    <= '0;
            last0      <= 4'd0;
            last1      <= 4'd0;
            rr         <= 1'b0;
            underrun   <= 2'b00;
            dac_data   <= 4'd0;
        end else begin
            frame_cnt  <= (frame_cnt == 16'd0) ? CNT_RELOAD : frame_cnt - 16'd1;
            frame_tick <= (frame_cnt == 16'd0);
            if (push0) wr_ptr0 <= wr_ptr0 + 1'b1;
            if (push1) wr_ptr1 <= wr_ptr1 + 1'b1;
            if (pop0)  rd_ptr0 <= rd_ptr0 + 1'b1;
            if (pop1)  rd_ptr1 <= rd_ptr1 + 1'b1;
            last0    <= nxt_last0;
            last1    <= nxt_last1;
            underrun <= clr_underrun ? 2'b00 : (underrun | urun_set);
            if (frame_tick) begin
                dac_data <= dac_nxt_p0;
                if (mode == 2'b11) rr <= ~rr;
            end
        end
    end

endmodule

// File: tb/tb_dac_audio_sched.sv
// Bench for dac_audio_sched: queue-based reference model stepped once per clock.
module tb_dac_audio_sched;
    localparam int FL    = 16;
    localparam int DEPTH = 4;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic [3:0] ch0_data = 4'd0, ch1_data = 4'd0;
    logic       ch0_valid = 1'b0, ch1_valid = 1'b0;
    logic       ch0_ready, ch1_ready;
    logic [1:0] mode = 2'b00;
    logic       clr_underrun = 1'b0;
    logic [3:0] dac_data;
    logic       frame_tick;
    logic [1:0] underrun;

    int checks = 0;
    int errors = 0;

    int       q0[$];
    int       q1[$];
    int       last0, last1, m_rr, m_dac, m_cyc;
    bit       m_tick;
    bit [1:0] m_urun;

    dac_audio_sched #(.FRAME_LEN(FL), .FIFO_DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .ch0_data(ch0_data), .ch0_valid(ch0_valid), .ch0_ready(ch0_ready),
        .ch1_data(ch1_data), .ch1_valid(ch1_valid), .ch1_ready(ch1_ready),
        .mode(mode), .clr_underrun(clr_underrun),
        .dac_data(dac_data), .frame_tick(frame_tick), .underrun(underrun)
    );

    always #5 Clk = ~Clk;

    function automatic logic [8:0] obs();
        return {dac_data, frame_tick, underrun, ch1_ready, ch0_ready};
    endfunction

    function automatic logic [8:0] model_vec();
        return {4'(m_dac), m_tick, m_urun, 1'(q1.size() < DEPTH), 1'(q0.size() < DEPTH)};
    endfunction

    // Apply the current inputs to the model, then advance the DUT one clock.
    task automatic step();
        bit       s0 = 0, s1 = 0, can0, can1;
        bit [1:0] set = 2'b00;
        can0 = (q0.size() < DEPTH);
        can1 = (q1.size() < DEPTH);
        if (m_tick) begin
            case (mode)
                2'b00:   begin s0 = 1; s1 = 1; end
                2'b01:   s0 = 1;
                2'b10:   s1 = 1;
                default: if (m_rr == 0) s0 = 1; else s1 = 1;
            endcase
            if (s0) begin if (q0.size() > 0) last0 = q0.pop_front(); else set[0] = 1; end
            if (s1) begin if (q1.size() > 0) last1 = q1.pop_front(); else set[1] = 1; end
            case (mode)
                2'b00:   m_dac = (last0 + last1 + 1) / 2;
                2'b01:   m_dac = last0;
                2'b10:   m_dac = last1;
                default: begin m_dac = s0 ? last0 : last1; m_rr = 1 - m_rr; end
            endcase
        end
        if (ch0_valid && can0) q0.push_back(int'(ch0_data));
        if (ch1_valid && can1) q1.push_back(int'(ch1_data));
        m_urun = clr_underrun ? 2'b00 : (m_urun | set);
        m_cyc++;
        m_tick = ((m_cyc % FL) == 0);
        @(posedge Clk);
        #1;
    endtask

    // Step until the cycle right after the next frame tick (DAC just updated).
    task automatic advance();
        step();
        while ((m_cyc % FL) != 1) step();
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        ch0_valid = 1'b0; ch1_valid = 1'b0; clr_underrun = 1'b0;
        q0.delete(); q1.delete();
        last0 = 0; last1 = 0; m_rr = 0; m_dac = 0; m_urun = 2'b00;
        m_tick = 0; m_cyc = 0;
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic push_pair(input logic [3:0] d0, input logic v0, input logic [3:0] d1, input logic v1);
        ch0_data = d0; ch0_valid = v0; ch1_data = d1; ch1_valid = v1;
        step();
        ch0_valid = 1'b0; ch1_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 Reset_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 9'b0000_0_00_11) begin
            errors++; $display("FAIL reset_values dut=%b required=%b", obs(), 9'b0000_0_00_11);
        end
        do_reset();
        for (int i = 1; i <= FL + 1; i++) begin
            step();
            checks++;
            if (frame_tick !== (i == FL) || obs() !== model_vec()) begin
                errors++; $display("FAIL first_tick clk=%0d tick=%b vec=%h required=%h", i, frame_tick, obs(), model_vec());
            end
        end
    endtask

    task automatic test_mix();
        logic [3:0] a [3] = '{4'd15, 4'd0, 4'd6};
        logic [3:0] b [3] = '{4'd15, 4'd1, 4'd9};
        logic [3:0] e [3] = '{4'd15, 4'd1, 4'd8};
        do_reset();
        mode = 2'b00;
        for (int k = 0; k < 3; k++) begin
            push_pair(a[k], 1'b1, b[k], 1'b1);
            advance();
            checks++;
            if (dac_data !== e[k] || obs() !== model_vec()) begin
                errors++; $display("FAIL mix_%0d dac=%0d required=%0d vec=%h model=%h", k, dac_data, e[k], obs(), model_vec());
            end
        end
    endtask

    task automatic test_ch_only();
        do_reset();
        mode = 2'b01;
        for (int i = 0; i < 5; i++) begin
            ch1_data = 4'(i + 2); ch1_valid = 1'b1;
            step();
            checks++;
            if (ch1_ready !== (i < 3)) begin
                errors++; $display("FAIL ch1_backpressure push=%0d ready=%b required=%b", i + 1, ch1_ready, (i < 3));
            end
        end
        ch1_valid = 1'b0;
        repeat (3) advance();
        checks++;
        if (ch1_ready !== 1'b0 || underrun !== 2'b01 || obs() !== model_vec()) begin
            errors++; $display("FAIL ch0_only_hold ready1=%b underrun=%b vec=%h model=%h", ch1_ready, underrun, obs(), model_vec());
        end
        mode = 2'b10;
        for (int k = 0; k < 4; k++) begin
            advance();
            checks++;
            if (dac_data !== 4'(k + 2) || obs() !== model_vec()) begin
                errors++; $display("FAIL ch1_drain_%0d dac=%0d required=%0d", k, dac_data, k + 2);
            end
        end
        checks++;
        if (ch1_ready !== 1'b1) begin
            errors++; $display("FAIL ch1_drained ready=%b required=1", ch1_ready);
        end
    endtask

    task automatic test_round_robin();
        int e [4] = '{3, 12, 3, 12};
        do_reset();
        mode = 2'b11;
        push_pair(4'd3, 1'b1, 4'd12, 1'b1);
        push_pair(4'd3, 1'b1, 4'd12, 1'b1);
        for (int k = 0; k < 4; k++) begin
            advance();
            checks++;
            if (dac_data !== 4'(e[k]) || underrun !== 2'b00) begin
                errors++; $display("FAIL rr_frame_%0d dac=%0d required=%0d underrun=%b", k, dac_data, e[k], underrun);
            end
        end
        advance();
        do_reset();
        push_pair(4'd5, 1'b1, 4'd10, 1'b1);
        advance();
        checks++;
        if (dac_data !== 4'd5 || obs() !== model_vec()) begin
            errors++; $display("FAIL rr_restart dac=%0d required=5", dac_data);
        end
    endtask

    task automatic test_underrun();
        do_reset();
        mode = 2'b00;
        push_pair(4'd2, 1'b1, 4'd8, 1'b1);
        advance();
        push_pair(4'd4, 1'b1, 4'd0, 1'b0);
        advance();
        checks++;
        if (dac_data !== 4'd6 || underrun !== 2'b10) begin
            errors++; $display("FAIL underrun_mix dac=%0d required=6 underrun=%b required=10", dac_data, underrun);
        end
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        checks++;
        if (underrun !== 2'b00) begin
            errors++; $display("FAIL underrun_clear underrun=%b required=00", underrun);
        end
        for (int i = 0; i < FL && !m_tick; i++) step();
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        checks++;
        if (underrun !== 2'b00 || obs() !== model_vec()) begin
            errors++; $display("FAIL clear_priority underrun=%b required=00", underrun);
        end
        advance();
        checks++;
        if (underrun !== 2'b11) begin
            errors++; $display("FAIL underrun_both underrun=%b required=11", underrun);
        end
    endtask

    task automatic test_tick_push();
        do_reset();
        mode = 2'b00;
        push_pair(4'd0, 1'b0, 4'd9, 1'b1);
        for (int i = 0; i < FL && !m_tick; i++) step();
        push_pair(4'd7, 1'b1, 4'd11, 1'b1);
        checks++;
        if (dac_data !== 4'd5 || underrun !== 2'b01 || obs() !== model_vec()) begin
            errors++; $display("FAIL tick_push_pop dac=%0d required=5 underrun=%b required=01", dac_data, underrun);
        end
        advance();
        checks++;
        if (dac_data !== 4'd9 || obs() !== model_vec()) begin
            errors++; $display("FAIL tick_push_stored dac=%0d required=9", dac_data);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        mode = 2'b00;
        push_pair(4'd9, 1'b1, 4'd13, 1'b1);
        advance();
        for (int i = 0; i < DEPTH; i++)
            push_pair(4'($urandom_range(1, 15)), 1'b1, 4'($urandom_range(1, 15)), 1'b1);
        checks++;
        if (dac_data !== 4'd11 || {ch1_ready, ch0_ready} !== 2'b00) begin
            errors++; $display("FAIL full_before_reset dac=%0d required=11 ready=%b required=00", dac_data, {ch1_ready, ch0_ready});
        end
        step();
        #3 Reset_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 9'b0000_0_00_11) begin
            errors++; $display("FAIL async_reset dut=%b required=%b", obs(), 9'b0000_0_00_11);
        end
        do_reset();
        for (int i = 1; i <= FL + 1; i++) begin
            step();
            checks++;
            if (frame_tick !== (i == FL) || obs() !== model_vec()) begin
                errors++; $display("FAIL restart_tick clk=%0d tick=%b vec=%h model=%h", i, frame_tick, obs(), model_vec());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < FL * 20; c++) begin
            if ((c % 5) == 0) mode = 2'($urandom_range(0, 3));
            ch0_data = 4'($urandom); ch0_valid = 1'($urandom_range(0, 2) == 0);
            ch1_data = 4'($urandom); ch1_valid = 1'($urandom_range(0, 2) == 0);
            clr_underrun = 1'($urandom_range(0, 15) == 0);
            step();
            checks++;
            if (obs() !== model_vec()) begin
                errors++; $display("FAIL random cyc=%0d dut=%h model=%h", c, obs(), model_vec());
            end
        end
        ch0_valid = 1'b0; ch1_valid = 1'b0; clr_underrun = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mix();
        test_ch_only();
        test_round_robin();
        test_underrun();
        test_tick_push();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
